// File: rtl/axi2apb_bridge.sv
// axi2apb_bridge: AXI slave to APB master bridge, one APB transfer per beat; AXI2APB_TIMEOUT_EN adds an ACCESS timeout
module axi2apb_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 255,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       s_axi_awid_i,
  input  logic [31:0]               s_axi_awaddr_i,
  input  logic [7:0]                s_axi_awlen_i,
  input  logic [1:0]                s_axi_awburst_i,
  input  logic [2:0]                s_axi_awprot_i,
  input  logic                      s_axi_awvalid_i,
  output logic                      s_axi_awready_o,
  input  logic [31:0]               s_axi_wdata_i,
  input  logic [3:0]                s_axi_wstrb_i,
  input  logic                      s_axi_wlast_i,
  input  logic                      s_axi_wvalid_i,
  output logic                      s_axi_wready_o,
  output logic [ID_WIDTH-1:0]       s_axi_bid_o,
  output logic [1:0]                s_axi_bresp_o,
  output logic                      s_axi_bvalid_o,
  input  logic                      s_axi_bready_i,
  input  logic [ID_WIDTH-1:0]       s_axi_arid_i,
  input  logic [31:0]               s_axi_araddr_i,
  input  logic [7:0]                s_axi_arlen_i,
  input  logic [1:0]                s_axi_arburst_i,
  input  logic [2:0]                s_axi_arprot_i,
  input  logic                      s_axi_arvalid_i,
  output logic                      s_axi_arready_o,
  output logic [ID_WIDTH-1:0]       s_axi_rid_o,
  output logic [31:0]               s_axi_rdata_o,
  output logic [1:0]                s_axi_rresp_o,
  output logic                      s_axi_rlast_o,
  output logic                      s_axi_rvalid_o,
  input  logic                      s_axi_rready_i,
  output logic                      m_apb_psel_o,
  output logic                      m_apb_penable_o,
  output logic [APB_ADDR_WIDTH-1:0] m_apb_paddr_o,
  output logic                      m_apb_pwrite_o,
  output logic [3:0]                m_apb_pstrb_o,
  output logic [2:0]                m_apb_pprot_o,
  output logic [31:0]               m_apb_pwdata_o,
  input  logic [31:0]               m_apb_prdata_i,
  input  logic                      m_apb_pready_i,
  input  logic                      m_apb_pslverr_i
);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, BRESP, RDATA} state_t;
  state_t                    state_q, state_d;
  logic                      aw_rdy_q, aw_rdy_d, ar_rdy_q, ar_rdy_d, last_wr_q, last_wr_d, wr_q, wr_d;
  logic                      err_q, err_d, rerr_q, rerr_d, last_q, last_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d, addr_nx;
  logic [7:0]                cnt_q, cnt_d;
  logic [1:0]                burst_q, burst_d;
  logic [2:0]                prot_q, prot_d;
  logic [31:0]               wdata_q, wdata_d, rdata_q, rdata_d, bdata;
  logic [3:0]                strb_q, strb_d;
  logic                      done, berr, unused_ok;
  assign unused_ok = ^{s_axi_wlast_i, s_axi_awaddr_i, s_axi_araddr_i};
`ifdef AXI2APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
  logic          to_hit;
  assign to_hit = !m_apb_pready_i && to_q == TW'(TIMEOUT_CYC - 1);
  assign done   = m_apb_pready_i | to_hit;
  assign berr   = m_apb_pslverr_i | to_hit;
  assign bdata  = to_hit ? 32'hDEAD_BEEF : m_apb_prdata_i;
  assign to_d   = state_q == ACCESS && !done ? to_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) to_q <= '0;
    else to_q <= to_d;
`else
  assign done  = m_apb_pready_i;
  assign berr  = m_apb_pslverr_i;
  assign bdata = m_apb_prdata_i;
`endif
  assign addr_nx = burst_q == 2'b00 || cnt_q == 8'd0 ? addr_q : addr_q + APB_ADDR_WIDTH'(4);
  always_comb begin
    state_d   = state_q;
    aw_rdy_d  = aw_rdy_q;
    ar_rdy_d  = ar_rdy_q;
    last_wr_d = last_wr_q;
    wr_d      = wr_q;
    err_d     = err_q;
    rerr_d    = rerr_q;
    last_d    = last_q;
    id_d      = id_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    prot_d    = prot_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    strb_d    = strb_q;
    case (state_q)
      IDLE:
        if (aw_rdy_q && s_axi_awvalid_i) begin
          {aw_rdy_d, ar_rdy_d, last_wr_d, wr_d} = 4'b0011;
          {id_d, cnt_d, burst_d, prot_d} = {s_axi_awid_i, s_axi_awlen_i, s_axi_awburst_i, s_axi_awprot_i};
          addr_d  = s_axi_awaddr_i[APB_ADDR_WIDTH-1:0];
          state_d = WDATA;
        end else if (ar_rdy_q && s_axi_arvalid_i) begin
          {aw_rdy_d, ar_rdy_d, last_wr_d, wr_d} = 4'b0000;
          {id_d, cnt_d, burst_d, prot_d} = {s_axi_arid_i, s_axi_arlen_i, s_axi_arburst_i, s_axi_arprot_i};
          addr_d  = s_axi_araddr_i[APB_ADDR_WIDTH-1:0];
          state_d = SETUP;
        end else begin
          // ready is registered one cycle ahead; write wins a tie unless it was served last
          aw_rdy_d = s_axi_awvalid_i && (!s_axi_arvalid_i || !last_wr_q);
          ar_rdy_d = s_axi_arvalid_i && !aw_rdy_d;
        end
      WDATA:
        if (s_axi_wvalid_i) begin
          wdata_d = s_axi_wdata_i;
          strb_d  = s_axi_wstrb_i;
          state_d = SETUP;
        end
      SETUP: state_d = ACCESS;
      ACCESS:
        if (done) begin
          last_d  = cnt_q == 8'd0;
          cnt_d   = cnt_q - 8'd1;
          addr_d  = addr_nx;
          err_d   = wr_q ? err_q | berr : err_q;
          rerr_d  = berr;
          rdata_d = wr_q ? rdata_q : bdata;
          state_d = !wr_q ? RDATA : cnt_q == 8'd0 ? BRESP : WDATA;
        end
      BRESP:
        if (s_axi_bready_i) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      RDATA: if (s_axi_rready_i) state_d = last_q ? IDLE : SETUP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      {aw_rdy_q, ar_rdy_q, last_wr_q, wr_q, err_q, rerr_q, last_q} <= '0;
      {id_q, addr_q, cnt_q, burst_q, prot_q} <= '0;
      {wdata_q, rdata_q, strb_q} <= '0;
    end else begin
      state_q <= state_d;
      {aw_rdy_q, ar_rdy_q, last_wr_q, wr_q, err_q, rerr_q, last_q} <=
        {aw_rdy_d, ar_rdy_d, last_wr_d, wr_d, err_d, rerr_d, last_d};
      {id_q, addr_q, cnt_q, burst_q, prot_q} <= {id_d, addr_d, cnt_d, burst_d, prot_d};
      {wdata_q, rdata_q, strb_q} <= {wdata_d, rdata_d, strb_d};
    end
  assign s_axi_awready_o = aw_rdy_q;
  assign s_axi_arready_o = ar_rdy_q;
  assign s_axi_wready_o  = state_q == WDATA;
  assign s_axi_bvalid_o  = state_q == BRESP;
  assign s_axi_bid_o     = id_q;
  assign s_axi_bresp_o   = {err_q, 1'b0};
  assign s_axi_rvalid_o  = state_q == RDATA;
  assign s_axi_rid_o     = id_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = {rerr_q, 1'b0};
  assign s_axi_rlast_o   = last_q;
  assign m_apb_psel_o    = state_q == SETUP || state_q == ACCESS;
  assign m_apb_penable_o = state_q == ACCESS;
  assign m_apb_paddr_o   = {addr_q[APB_ADDR_WIDTH-1:2], 2'b00};
  assign m_apb_pwrite_o  = wr_q;
  assign m_apb_pstrb_o   = wr_q ? strb_q : 4'b0000;
  assign m_apb_pprot_o   = prot_q;
  assign m_apb_pwdata_o  = wdata_q;
endmodule
